pixel_walk_addr_gen: RTL and testbench

Sequential address generator for the Julia worker's framebuffer write path. It takes one rectangular tile request and emits one framebuffer byte address per pixel in raster order over a valid/ready stream. Addressing is parametrised in address and coordinate width, with a runtime-selectable pixel size. It sits between the tile scheduler (start/config) and the pixel write master (address stream consumer).

---
 rtl/julia_addr_pkg.sv | 14 +
 rtl/pixel_walk_addr_gen_if.sv | 15 +
 rtl/start_addr_calc.sv | 17 +
 rtl/pixel_walk_addr_gen.sv | 112 +++++++++++
 tb/tb_pixel_walk_addr_gen.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/julia_addr_pkg.sv
// Shared types and constants for the framebuffer pixel-walk address generator.
package julia_addr_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int COORD_W_DEF = 10;

  localparam logic [1:0] PIX_8BPP  = 2'd0;
  localparam logic [1:0] PIX_16BPP = 2'd1;
  localparam logic [1:0] PIX_32BPP = 2'd2;
  localparam logic [1:0] PIX_64BPP = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

endpackage

// File: rtl/pixel_walk_addr_gen_if.sv
// Address beat stream from the generator to the pixel write master.
interface pixel_walk_addr_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int COORD_W = 10
);
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_addr;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic               out_last;

  modport master (output out_valid, out_addr, out_x, out_y, out_last, input out_ready);
  modport slave  (input out_valid, out_addr, out_x, out_y, out_last, output out_ready);
endinterface

// File: rtl/start_addr_calc.sv
// Tile origin byte address: offset + ((y0*frame_width + x0) << pixel_shift), mod 2^ADDR_W.
module start_addr_calc #(
  parameter int ADDR_W  = 32,
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] frame_width,
  input  logic [1:0]         pixel_shift,
  input  logic [ADDR_W-1:0]  offset,
  output logic [ADDR_W-1:0]  start_addr
);
  logic [ADDR_W-1:0] lin;

  assign lin        = ADDR_W'(y0) * ADDR_W'(frame_width) + ADDR_W'(x0);
  assign start_addr = offset + (lin << pixel_shift);
endmodule

// File: rtl/pixel_walk_addr_gen.sv
// Walks a rectangular tile in raster order, one framebuffer byte address per beat.
module pixel_walk_addr_gen
  import julia_addr_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic [COORD_W-1:0] frame_width,
  input  logic [1:0]         pixel_shift,
  input  logic [ADDR_W-1:0]  offset,
  output logic               busy,
  output logic               done,
  output logic               err,
  pixel_walk_addr_gen_if.master os
);
  state_t state_q, state_d;

  logic [COORD_W-1:0] x0_q, y0_q, xe_q, ye_q, fw_q;
  logic [1:0]         sh_q;
  logic [ADDR_W-1:0]  off_q, row_base_q, start_addr, stride, step;
  logic [COORD_W-1:0] x_inc, y_inc;
  logic               illegal;

  start_addr_calc #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) u_calc (
    .x0(x0_q), .y0(y0_q), .frame_width(fw_q), .pixel_shift(sh_q),
    .offset(off_q), .start_addr(start_addr)
  );

  assign illegal = (width == '0) || (height == '0);
  assign stride  = ADDR_W'(fw_q) << sh_q;
  assign step    = ADDR_W'(1) << sh_q;
  assign x_inc   = os.out_x + COORD_W'(1);
  assign y_inc   = os.out_y + COORD_W'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start && !illegal) state_d = SETUP;
      SETUP: begin busy = 1'b1; state_d = RUN; end
      RUN: begin
        busy = 1'b1;
        if (os.out_valid && os.out_ready && os.out_last) state_d = DONE;
      end
      DONE:  begin done = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x0_q <= '0; y0_q <= '0; xe_q <= '0; ye_q <= '0; fw_q <= '0; sh_q <= '0;
      off_q <= '0; row_base_q <= '0; err <= 1'b0;
      os.out_valid <= 1'b0; os.out_last <= 1'b0;
      os.out_addr <= '0; os.out_x <= '0; os.out_y <= '0;
    end else begin
      err <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          x0_q  <= x0;
          y0_q  <= y0;
          xe_q  <= x0 + width - COORD_W'(1);
          ye_q  <= y0 + height - COORD_W'(1);
          fw_q  <= frame_width;
          sh_q  <= pixel_shift;
          off_q <= offset;
          err   <= illegal;
        end
        SETUP: row_base_q <= start_addr;
        RUN: begin
          // First RUN cycle primes the output register from the stored row base.
          if (!os.out_valid) begin
            os.out_valid <= 1'b1;
            os.out_addr  <= row_base_q;
            os.out_x     <= x0_q;
            os.out_y     <= y0_q;
            os.out_last  <= (x0_q == xe_q) && (y0_q == ye_q);
          end else if (os.out_ready) begin
            if (os.out_last) begin
              os.out_valid <= 1'b0;
              os.out_last  <= 1'b0;
            end else if (os.out_x == xe_q) begin
              os.out_x    <= x0_q;
              os.out_y    <= y_inc;
              row_base_q  <= row_base_q + stride;
              os.out_addr <= row_base_q + stride;
              os.out_last <= (x0_q == xe_q) && (y_inc == ye_q);
            end else begin
              os.out_x    <= x_inc;
              os.out_addr <= os.out_addr + step;
              os.out_last <= (x_inc == xe_q) && (os.out_y == ye_q);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_walk_addr_gen.sv
// Directed bench for pixel_walk_addr_gen: latency, raster order, backpressure, err, wrap, reset.
module tb_pixel_walk_addr_gen;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [9:0]  x0, y0, width, height, frame_width;
  logic [1:0]  pixel_shift;
  logic [31:0] offset;
  logic        busy, done, err;

  pixel_walk_addr_gen_if #(.ADDR_W(32), .COORD_W(10)) os ();

  pixel_walk_addr_gen #(.ADDR_W(32), .COORD_W(10)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .x0(x0), .y0(y0),
    .width(width), .height(height), .frame_width(frame_width),
    .pixel_shift(pixel_shift), .offset(offset),
    .busy(busy), .done(done), .err(err), .os(os)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] b_addr [8];
  logic [9:0]  b_x [8], b_y [8];
  logic        b_last [8];
  int          nb, first_valid;
  bit          tmo, hold_bad, done_early;
  logic        done_after, busy_after, valid_after;

  // Config is scrambled right after the start edge: the DUT must use its latched copy.
  task automatic do_start(input logic [9:0] ax0, ay0, aw, ah, afw,
                          input logic [1:0] ash, input logic [31:0] aoff);
    @(negedge clk);
    x0 = ax0; y0 = ay0; width = aw; height = ah; frame_width = afw;
    pixel_shift = ash; offset = aoff; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x0 = 10'h3FF; y0 = 10'h3FF; width = 10'd7; height = 10'd7;
    frame_width = 10'd3; pixel_shift = 2'd0; offset = 32'h5555_5555;
  endtask

  task automatic collect(input int stall_beat, input int stall_n);
    int stalls = 0;
    logic [31:0] ha;
    logic [9:0]  hx, hy;
    nb = 0; tmo = 1; hold_bad = 0; done_early = 0; first_valid = -1;
    ha = '0; hx = '0; hy = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) done_early = 1;
      if (os.out_valid) begin
        if (first_valid < 0) first_valid = c;
        if (nb == stall_beat && stalls < stall_n) begin
          if (stalls == 0) begin ha = os.out_addr; hx = os.out_x; hy = os.out_y; end
          else if (os.out_addr !== ha || os.out_x !== hx || os.out_y !== hy) hold_bad = 1;
          os.out_ready = 1'b0;
          stalls++;
        end else begin
          if (stalls > 0 && nb == stall_beat &&
              (os.out_addr !== ha || os.out_x !== hx || os.out_y !== hy)) hold_bad = 1;
          os.out_ready = 1'b1;
          if (nb < 8) begin
            b_addr[nb] = os.out_addr; b_x[nb] = os.out_x;
            b_y[nb] = os.out_y; b_last[nb] = os.out_last;
          end
          nb++;
          if (os.out_last) begin
            @(negedge clk);
            done_after = done; busy_after = busy; valid_after = os.out_valid;
            tmo = 0;
            break;
          end
        end
      end else os.out_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({os.out_valid, os.out_last, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {os.out_valid, os.out_last, busy, done, err});
    end
    checks++;
    if (os.out_addr !== 32'h0 || os.out_x !== 10'h0 || os.out_y !== 10'h0) begin
      errors++; $display("FAIL reset_data got=%h/%0d/%0d exp=0/0/0", os.out_addr, os.out_x, os.out_y);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_basic(input string tag, input int stall_beat, input int stall_n);
    logic [31:0] ea [4];
    logic [9:0]  ex [4], ey [4];
    ea = '{32'h0800_0000, 32'h0800_0004, 32'h0800_0A00, 32'h0800_0A04};
    ex = '{10'd0, 10'd1, 10'd0, 10'd1};
    ey = '{10'd0, 10'd0, 10'd1, 10'd1};
    do_start(10'd0, 10'd0, 10'd2, 10'd2, 10'd640, 2'd2, 32'h0800_0000);
    checks++;
    if (busy !== 1'b1 || os.out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_k busy/valid got=%b%b exp=10", tag, busy, os.out_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || os.out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_k1 busy/valid got=%b%b exp=10", tag, busy, os.out_valid);
    end
    collect(stall_beat, stall_n);
    checks++;
    if (tmo || nb != 4) begin
      errors++; $display("FAIL %s_count got=%0d timeout=%0d exp=4 timeout=0", tag, nb, tmo);
    end
    checks++;
    if (first_valid != 0) begin
      errors++; $display("FAIL %s_latency got=%0d exp=0 cycles after k+2", tag, first_valid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b_addr[i] !== ea[i] || b_x[i] !== ex[i] || b_y[i] !== ey[i] || b_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL %s_beat%0d got=%h x=%0d y=%0d last=%b exp=%h x=%0d y=%0d last=%b",
                 tag, i, b_addr[i], b_x[i], b_y[i], b_last[i], ea[i], ex[i], ey[i], i == 3);
      end
    end
    checks++;
    if (hold_bad) begin
      errors++; $display("FAIL %s_hold got=unstable exp=stable", tag);
    end
    checks++;
    if (done_after !== 1'b1 || busy_after !== 1'b0 || valid_after !== 1'b0 || done_early) begin
      errors++;
      $display("FAIL %s_done got=done%b busy%b valid%b early%0d exp=done1 busy0 valid0 early0",
               tag, done_after, busy_after, valid_after, done_early);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL %s_done_pulse got=%b exp=0", tag, done);
    end
  endtask

  task automatic test_single();
    do_start(10'd1, 10'd2, 10'd1, 10'd1, 10'd640, 2'd2, 32'h0800_0000);
    @(negedge clk);
    collect(-1, 0);
    checks++;
    if (tmo || nb != 1 || b_addr[0] !== 32'h0800_1404 || b_x[0] !== 10'd1 ||
        b_y[0] !== 10'd2 || b_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL single got=n%0d %h x=%0d y=%0d last=%b exp=n1 08001404 x=1 y=2 last=1",
               nb, b_addr[0], b_x[0], b_y[0], b_last[0]);
    end
    checks++;
    if (done_after !== 1'b1) begin
      errors++; $display("FAIL single_done got=%b exp=1", done_after);
    end
  endtask

  task automatic test_illegal();
    bit saw_valid = 0;
    do_start(10'd0, 10'd0, 10'd0, 10'd2, 10'd640, 2'd2, 32'h0800_0000);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_err got=err%b busy%b exp=err1 busy0", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse got=err%b busy%b exp=err0 busy0", err, busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (os.out_valid || busy) saw_valid = 1;
    end
    checks++;
    if (saw_valid) begin
      errors++; $display("FAIL illegal_idle got=active exp=idle");
    end
  endtask

  task automatic test_wrap();
    do_start(10'd0, 10'd0, 10'd2, 10'd1, 10'd640, 2'd2, 32'hFFFF_FFFC);
    @(negedge clk);
    collect(-1, 0);
    checks++;
    if (tmo || nb != 2 || b_addr[0] !== 32'hFFFF_FFFC || b_addr[1] !== 32'h0 ||
        b_last[0] !== 1'b0 || b_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap got=n%0d %h %h last=%b%b exp=n2 fffffffc 00000000 last=01",
               nb, b_addr[0], b_addr[1], b_last[0], b_last[1]);
    end
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    bit reached = 0;
    do_start(10'd0, 10'd0, 10'd2, 10'd2, 10'd640, 2'd2, 32'h0800_0000);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      os.out_ready = 1'b1;
      if (os.out_valid) begin
        if (n == 2) begin reached = 1; break; end
        n++;
      end
    end
    checks++;
    if (!reached || os.out_addr !== 32'h0800_0A00) begin
      errors++; $display("FAIL rst_beat3 got=%h reached=%0d exp=08000a00 reached=1", os.out_addr, reached);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({os.out_valid, os.out_last, busy, done, err} !== 5'b0 ||
        os.out_addr !== 32'h0 || os.out_x !== 10'h0 || os.out_y !== 10'h0) begin
      errors++;
      $display("FAIL rst_async got=%b %h %0d %0d exp=00000 0 0 0",
               {os.out_valid, os.out_last, busy, done, err}, os.out_addr, os.out_x, os.out_y);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_nodone got=done%b busy%b exp=done0 busy0", done, busy);
    end
    n_rst = 1'b1;
    test_basic("rerun", -1, 0);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; x0 = '0; y0 = '0; width = '0; height = '0;
    frame_width = '0; pixel_shift = '0; offset = '0; os.out_ready = 1'b1;
    test_reset();
    test_basic("basic", -1, 0);
    test_single();
    test_basic("bp", 1, 3);
    test_illegal();
    test_wrap();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
